keypad_code_lock: RTL and testbench
===================================

# keypad_code_lock

Sequential consumer of the three debounced single-cycle key pulses produced by the triple key debouncer. Key "0" and key "1" pulses enter code digits; key "2" is ENTER. The block compares the entered sequence with a parameterised code. On a match it drives a timed unlock output. On a mismatch it flags an error and counts failures, and after too many failures it enters a timed lockout.

## Interface
Parameters:
- CODE_LEN, 4: number of binary digits in the code (1..16).
- CODE, 4'b1011: reference code, CODE_LEN bits wide; the first digit entered is compared with the MSB.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1).
- OPEN_CYCLES, 50_000_000: sysclk cycles that unlock stays high.
- LOCKOUT_CYCLES, 250_000_000: sysclk cycles spent in lockout.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- key0_p  in  1  debounced single-cycle pulse, digit "0".
- key1_p  in  1  debounced single-cycle pulse, digit "1".
- key2_p  in  1  debounced single-cycle pulse, ENTER.
- unlock  out  1  high while in OPEN.
- err  out  1  one-cycle pulse on a failed check.
- locked_out  out  1  high while in LOCKOUT.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits entered in the current attempt.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures so far.

## Operation
States: ENTRY, CHECK, OPEN, LOCKOUT. All outputs are registered.

Reset:
- state=ENTRY.
- Shift register, digit_cnt, fail_cnt and both timers = 0.
- unlock=err=locked_out=0.
- Reset wins over every other event in the same cycle, including mid-OPEN and mid-LOCKOUT.

Valid key:
- A key is valid only if exactly one of key0_p/key1_p/key2_p is high in a cycle.
- If two or more are high in the same cycle, all are ignored.

ENTRY:
- A valid key0/key1 pulse with digit_cnt<CODE_LEN shifts left: shreg <= {shreg[CODE_LEN-2:0], bit}, and digit_cnt increments.
- Digits arriving when digit_cnt==CODE_LEN are ignored; there is no wrap and no overwrite.
- A valid key2 pulse moves to CHECK, even with zero digits entered.

CHECK (exactly one cycle):
- match = (digit_cnt==CODE_LEN) && (shreg==CODE).
- In all cases: shreg and digit_cnt are cleared.
- On match:
  - fail_cnt is cleared.
  - Go to OPEN and load the open timer with OPEN_CYCLES-1.
- On mismatch:
  - err is pulsed for one cycle.
  - If fail_cnt+1==MAX_FAIL: fail_cnt is set to MAX_FAIL, go to LOCKOUT, and load the lockout timer with LOCKOUT_CYCLES-1.
  - Otherwise: fail_cnt increments and the state returns to ENTRY.
- Key pulses arriving during CHECK are ignored.

OPEN:
- unlock=1.
- The timer decrements each cycle.
- When the timer reaches 0, or on a valid key2 pulse (early relock), go to ENTRY.
- Digit pulses are ignored.

LOCKOUT:
- locked_out=1.
- All keys are ignored.
- The timer decrements each cycle. At 0: go to ENTRY and clear fail_cnt.

Timer width is $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)). Timers never underflow.

## Timing
- Digit pulse in cycle n: digit_cnt is updated in cycle n+1.
- ENTER pulse in cycle n: state=CHECK in cycle n+1. In cycle n+2, unlock=1, or err=1 (err is high for that cycle only), or locked_out=1.
- Success: unlock is high for exactly OPEN_CYCLES cycles, starting at n+2, unless an early key2 is received. A key2 in OPEN cycle m gives unlock=0 in cycle m+1.
- Lockout: locked_out is high for exactly LOCKOUT_CYCLES cycles. A key accepted in the first ENTRY cycle after lockout is processed.
- Throughput: one key per cycle is accepted in ENTRY. The upstream debouncer guarantees pulses are at least one heartbeat apart, but the block does not rely on that.

## Test plan
Each scenario uses CODE_LEN=4, CODE=4'b1011, MAX_FAIL=3, OPEN_CYCLES=8, LOCKOUT_CYCLES=16.
- Reset, then keys 1,0,1,1, ENTER -> two cycles after ENTER, unlock=1 for 8 cycles; fail_cnt=0; digit_cnt=0.
- Keys 1,0,0,1, ENTER -> err pulses for one cycle; fail_cnt=1; state=ENTRY; unlock stays 0.
- Three wrong attempts -> err pulses three times; on the third, locked_out=1 for 16 cycles. Keys 1,0,1,1 pressed mid-lockout have no effect. Afterwards fail_cnt=0, and the correct code then unlocks.
- Five digits 1,0,1,1,0, ENTER -> the fifth digit is ignored (digit_cnt stays 4) and unlock=1. Separately, three digits then ENTER -> err.
- key0_p and key1_p high in the same cycle -> digit_cnt unchanged. key2 during OPEN at cycle 3 -> unlock=0 on the next cycle.
- reset asserted mid-OPEN and mid-LOCKOUT -> next cycle: unlock=locked_out=err=0, fail_cnt=0, digit_cnt=0, state=ENTRY.

Source files
------------

// File: rtl/keypad_code_lock.sv
// Binary keypad code lock: shifts in digits from debounced key pulses, checks them
// against CODE on ENTER, and drives a timed unlock or, after repeated failures, a timed lockout.
module keypad_code_lock #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  OPEN_CYCLES    = 50_000_000,
    parameter int                  LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                               sysclk,
    input  logic                               reset,
    input  logic                               key0_p,
    input  logic                               key1_p,
    input  logic                               key2_p,
    output logic                               unlock,
    output logic                               err,
    output logic                               locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0]  CODE_LEN_C = CNT_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } state_e;

    state_e              state_q,      state_d;
    logic [CODE_LEN-1:0] shreg_q,      shreg_d;
    logic [CNT_W-1:0]    digit_cnt_q,  digit_cnt_d;
    logic [FAIL_W-1:0]   fail_cnt_q,   fail_cnt_d;
    logic [TMR_W-1:0]    tmr_q,        tmr_d;
    logic                unlock_q,     unlock_d;
    logic                err_q,        err_d;
    logic                locked_out_q, locked_out_d;

    logic key_valid;
    logic digit_key;
    logic enter_key;
    logic match;

    // Simultaneous pulses are ambiguous, so only a lone pulse counts as a key press.
    always_comb begin
        key_valid = $onehot({key0_p, key1_p, key2_p});
        digit_key = key_valid && (key0_p || key1_p);
        enter_key = key_valid && key2_p;
        match     = (digit_cnt_q == CODE_LEN_C) && (shreg_q == CODE);
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        tmr_d       = tmr_q;
        err_d       = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (digit_key) begin
                    if (digit_cnt_q < CODE_LEN_C) begin
                        shreg_d     = CODE_LEN'({shreg_q, key1_p});
                        digit_cnt_d = digit_cnt_q + CNT_W'(1);
                    end
                end else if (enter_key) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                shreg_d     = '0;
                digit_cnt_d = '0;
                if (match) begin
                    fail_cnt_d = '0;
                    tmr_d      = OPEN_LOAD;
                    state_d    = ST_OPEN;
                end else begin
                    err_d = 1'b1;
                    if (fail_cnt_q + FAIL_W'(1) == MAX_FAIL_C) begin
                        fail_cnt_d = MAX_FAIL_C;
                        tmr_d      = LOCK_LOAD;
                        state_d    = ST_LOCKOUT;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        state_d    = ST_ENTRY;
                    end
                end
            end

            ST_OPEN: begin
                if (tmr_q == '0 || enter_key) begin
                    tmr_d   = '0;
                    state_d = ST_ENTRY;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_LOCKOUT: begin
                if (tmr_q == '0) begin
                    fail_cnt_d = '0;
                    state_d    = ST_ENTRY;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        unlock_d     = (state_d == ST_OPEN);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            shreg_q      <= '0;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            tmr_q        <= '0;
            unlock_q     <= 1'b0;
            err_q        <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            digit_cnt_q  <= digit_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            tmr_q        <= tmr_d;
            unlock_q     <= unlock_d;
            err_q        <= err_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign unlock     = unlock_q;
    assign err        = err_q;
    assign locked_out = locked_out_q;
    assign digit_cnt  = digit_cnt_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Self-checking bench for keypad_code_lock: directed scenarios followed by random key traffic,
// all compared every cycle against a behavioural model of the lock's rules.
module tb_keypad_code_lock;

    localparam int             CODE_LEN       = 4;
    localparam logic [3:0]     CODE           = 4'b1011;
    localparam int             MAX_FAIL       = 3;
    localparam int             OPEN_CYCLES    = 8;
    localparam int             LOCKOUT_CYCLES = 16;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       key0_p = 1'b0;
    logic       key1_p = 1'b0;
    logic       key2_p = 1'b0;
    logic       unlock;
    logic       err;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    keypad_code_lock #(
        .CODE_LEN      (CODE_LEN),
        .CODE          (CODE),
        .MAX_FAIL      (MAX_FAIL),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .key0_p    (key0_p),
        .key1_p    (key1_p),
        .key2_p    (key2_p),
        .unlock    (unlock),
        .err       (err),
        .locked_out(locked_out),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: entered digits as a queue, remaining open/lockout cycles as plain counts.
    bit digits[$];
    int fails        = 0;
    int open_left    = 0;
    int lock_left    = 0;
    bit check_pend   = 0;
    bit exp_err      = 0;

    // Per-scenario tallies of observed output activity.
    int unlock_cycles = 0;
    int lock_cycles   = 0;
    int err_pulses    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int entered_value();
        int v = 0;
        foreach (digits[i]) v = (v << 1) | int'(digits[i]);
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit k0, input bit k1, input bit k2);
        bit valid;
        bit match;
        valid   = (int'(k0) + int'(k1) + int'(k2)) == 1;
        exp_err = 0;
        if (rst) begin
            digits.delete();
            fails      = 0;
            open_left  = 0;
            lock_left  = 0;
            check_pend = 0;
        end else if (check_pend) begin
            check_pend = 0;
            match = (digits.size() == CODE_LEN) && (entered_value() == int'(CODE));
            digits.delete();
            if (match) begin
                fails     = 0;
                open_left = OPEN_CYCLES;
            end else begin
                exp_err = 1;
                fails++;
                if (fails == MAX_FAIL) lock_left = LOCKOUT_CYCLES;
            end
        end else if (open_left > 0) begin
            if (valid && k2) open_left = 0;
            else             open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else begin
            if (valid && (k0 || k1)) begin
                if (digits.size() < CODE_LEN) digits.push_back(k1);
            end else if (valid && k2) begin
                check_pend = 1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare every output.
    task automatic tick(input bit rst, input bit k0, input bit k1, input bit k2);
        reset  = rst;
        key0_p = k0;
        key1_p = k1;
        key2_p = k2;
        @(posedge sysclk);
        model_step(rst, k0, k1, k2);
        #1;
        check("unlock",     unlock,     32'(open_left > 0));
        check("locked_out", locked_out, 32'(lock_left > 0));
        check("err",        err,        32'(exp_err));
        check("digit_cnt",  digit_cnt,  32'(digits.size()));
        check("fail_cnt",   fail_cnt,   32'(fails));
        if (unlock === 1'b1)     unlock_cycles++;
        if (locked_out === 1'b1) lock_cycles++;
        if (err === 1'b1)        err_pulses++;
    endtask

    task automatic press(input int k);
        tick(1'b0, k == 0, k == 1, k == 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [3:0] code);
        logic [3:0] c;
        c = code;
        for (int i = 3; i >= 0; i--) press(int'(c[i]));
        press(2);
    endtask

    task automatic clear_tallies();
        unlock_cycles = 0;
        lock_cycles   = 0;
        err_pulses    = 0;
    endtask

    initial begin
        int r;

        // Correct code unlocks for exactly OPEN_CYCLES cycles.
        do_reset();
        check("reset_digit_cnt", digit_cnt, 0);
        check("reset_unlock", unlock, 0);
        clear_tallies();
        enter_code(4'b1011);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_unlock_two_after_enter", unlock, 1);
        idle(12);
        check("s1_unlock_cycles", unlock_cycles, 8);
        check("s1_fail_cnt", fail_cnt, 0);

        // Wrong code: single err pulse, one failure recorded.
        clear_tallies();
        enter_code(4'b1001);
        idle(3);
        check("s2_err_pulses", err_pulses, 1);
        check("s2_fail_cnt", fail_cnt, 1);
        check("s2_unlock_cycles", unlock_cycles, 0);

        // Three failures: lockout, keys ignored meanwhile, then recovery.
        do_reset();
        clear_tallies();
        enter_code(4'b0000); idle(2);
        enter_code(4'b1111); idle(2);
        enter_code(4'b0011);
        idle(1);
        press(1); press(0); press(1); press(1);
        check("s3_digits_ignored", digit_cnt, 0);
        idle(16);
        check("s3_err_pulses", err_pulses, 3);
        check("s3_lock_cycles", lock_cycles, 16);
        check("s3_fail_cnt_after", fail_cnt, 0);
        clear_tallies();
        enter_code(4'b1011);
        idle(10);
        check("s3_unlock_after_lockout", unlock_cycles, 8);

        // Fifth digit is dropped; a short code is rejected.
        do_reset();
        clear_tallies();
        press(1); press(0); press(1); press(1); press(0);
        check("s4_digit_cap", digit_cnt, 4);
        press(2);
        idle(10);
        check("s4_unlock_cycles", unlock_cycles, 8);
        clear_tallies();
        press(1); press(0); press(1); press(2);
        idle(2);
        check("s4_short_err", err_pulses, 1);

        // Simultaneous keys ignored; early relock with ENTER while open.
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("s5_multi_key", digit_cnt, 0);
        enter_code(4'b1011);
        idle(1);
        press(0);
        idle(1);
        check("s5_still_open", unlock, 1);
        press(2);
        check("s5_early_relock", unlock, 0);

        // Reset mid-OPEN and mid-LOCKOUT.
        enter_code(4'b1011);
        idle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("s6_rst_open_unlock", unlock, 0);
        check("s6_rst_open_fail", fail_cnt, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        enter_code(4'b0000); idle(2);
        enter_code(4'b0000); idle(2);
        enter_code(4'b0000);
        idle(5);
        check("s6_in_lockout", locked_out, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("s6_rst_lock_locked", locked_out, 0);
        check("s6_rst_lock_fail", fail_cnt, 0);
        check("s6_rst_lock_err", err, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                tick(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                r = int'($urandom_range(0, 9));
                case (r)
                    4, 5:    press(0);
                    6, 7:    press(1);
                    8:       press(2);
                    9: begin
                        logic [2:0] m;
                        m = 3'($urandom);
                        tick(1'b0, m[0], m[1], m[2]);
                    end
                    default: idle(1);
                endcase
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
